// File: rtl/axi_lite_regfile_disp_if.sv
// Bus bundle between the switch/button master logic and the register slave.
// Signal prefixes show the driver: ms_* come from the master, sm_* from the slave.
// Five independent channels:
//   AW  ms_awvalid, ms_awaddr, sm_awready   write address
//   W   ms_wvalid,  ms_wdata,  sm_wready    write data
//   B   sm_bvalid,  sm_bresp,  ms_bready    write response (00 OKAY, 10 SLVERR)
//   AR  ms_arvalid, ms_araddr, sm_arready   read address
//   R   sm_rvalid,  sm_rdata,  sm_rresp, ms_rready   read data and response
interface axi_lite_regfile_disp_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              ms_awvalid;
   logic [ADDR_W-1:0] ms_awaddr;
   logic              sm_awready;
   logic              ms_wvalid;
   logic [DATA_W-1:0] ms_wdata;
   logic              sm_wready;
   logic              sm_bvalid;
   logic [1:0]        sm_bresp;
   logic              ms_bready;
   logic              ms_arvalid;
   logic [ADDR_W-1:0] ms_araddr;
   logic              sm_arready;
   logic              sm_rvalid;
   logic [DATA_W-1:0] sm_rdata;
   logic [1:0]        sm_rresp;
   logic              ms_rready;

   modport master (
      output ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_bready,
             ms_arvalid, ms_araddr, ms_rready,
      input  sm_awready, sm_wready, sm_bvalid, sm_bresp,
             sm_arready, sm_rvalid, sm_rdata, sm_rresp
   );

   modport slave (
      input  ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_bready,
             ms_arvalid, ms_araddr, ms_rready,
      output sm_awready, sm_wready, sm_bvalid, sm_bresp,
             sm_arready, sm_rvalid, sm_rdata, sm_rresp
   );
endinterface

// File: rtl/axi_lite_regfile_disp.sv
// AXI-Lite-style register slave holding DEPTH x DATA_W registers. Writes and
// reads run on independent state machines; out-of-range addresses answer
// SLVERR. The low nibble of every OKAY read is shown on a seven-segment digit.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   bus         slave side of the AW/W/B/AR/R bundle
//   disp_hex_r  {dp,g,f,e,d,c,b,a}, active-high segments
module axi_lite_regfile_disp #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   axi_lite_regfile_disp_if.slave    bus,
   output logic [7:0]                disp_hex_r
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_COLLECT, W_RESP} w_state_t;
   typedef enum logic {R_ADDR, R_DATA} r_state_t;

   function automatic logic addr_mapped(input logic [ADDR_W-1:0] a);
      return 32'(a) < DEPTH;
   endfunction

   function automatic logic [7:0] seg_encode(input logic [3:0] n);
      case (n)
         4'h0: return 8'h3F;
         4'h1: return 8'h06;
         4'h2: return 8'h5B;
         4'h3: return 8'h4F;
         4'h4: return 8'h66;
         4'h5: return 8'h6D;
         4'h6: return 8'h7D;
         4'h7: return 8'h07;
         4'h8: return 8'h7F;
         4'h9: return 8'h6F;
         4'hA: return 8'h77;
         4'hB: return 8'h7C;
         4'hC: return 8'h39;
         4'hD: return 8'h5E;
         4'hE: return 8'h79;
         default: return 8'h71;
      endcase
   endfunction

   w_state_t          w_state_q, w_state_d;
   logic              aw_cap_q, aw_cap_d;
   logic              w_cap_q, w_cap_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   r_state_t          r_state_q, r_state_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [7:0]        disp_q, disp_d;

   logic              aw_hs, w_hs, ar_hs;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign aw_hs = bus.ms_awvalid && awready_q;
   assign w_hs  = bus.ms_wvalid && wready_q;
   assign ar_hs = bus.ms_arvalid && arready_q;

   // Whichever half arrives last is taken straight from the bus so the write
   // commits on that same edge instead of one cycle later.
   assign wr_addr = aw_cap_q ? awaddr_q : bus.ms_awaddr;
   assign wr_data = w_cap_q  ? wdata_q  : bus.ms_wdata;

   always_comb begin
      w_state_d = w_state_q;
      aw_cap_d  = aw_cap_q;
      w_cap_d   = w_cap_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_d     = mem_q;
      case (w_state_q)
         W_COLLECT: begin
            if (aw_hs) begin
               aw_cap_d  = 1'b1;
               awaddr_d  = bus.ms_awaddr;
               awready_d = 1'b0;
            end
            if (w_hs) begin
               w_cap_d  = 1'b1;
               wdata_d  = bus.ms_wdata;
               wready_d = 1'b0;
            end
            if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
               if (addr_mapped(wr_addr)) begin
                  mem_d[wr_addr] = wr_data;
                  bresp_d        = RESP_OKAY;
               end else begin
                  bresp_d = RESP_SLVERR;
               end
               bvalid_d  = 1'b1;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               w_state_d = W_RESP;
            end
         end
         default: begin
            if (bus.ms_bready) begin
               bvalid_d  = 1'b0;
               aw_cap_d  = 1'b0;
               w_cap_d   = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_COLLECT;
            end
         end
      endcase
   end

   // Reads sample mem_q, so a read committing alongside a write to the same
   // address returns the pre-write value.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      disp_d    = disp_q;
      case (r_state_q)
         R_ADDR: begin
            if (ar_hs) begin
               if (addr_mapped(bus.ms_araddr)) begin
                  rdata_d = mem_q[bus.ms_araddr];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
               rvalid_d  = 1'b1;
               arready_d = 1'b0;
               r_state_d = R_DATA;
            end
         end
         default: begin
            if (bus.ms_rready) begin
               if (rresp_q == RESP_OKAY) disp_d = seg_encode(rdata_q[3:0]);
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_ADDR;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_state_q <= W_COLLECT;
         aw_cap_q  <= 1'b0;
         w_cap_q   <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         r_state_q <= R_ADDR;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         disp_q    <= 8'h3F;
      end else begin
         w_state_q <= w_state_d;
         aw_cap_q  <= aw_cap_d;
         w_cap_q   <= w_cap_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         mem_q     <= mem_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         disp_q    <= disp_d;
      end
   end

   assign bus.sm_awready = awready_q;
   assign bus.sm_wready  = wready_q;
   assign bus.sm_bvalid  = bvalid_q;
   assign bus.sm_bresp   = bresp_q;
   assign bus.sm_arready = arready_q;
   assign bus.sm_rvalid  = rvalid_q;
   assign bus.sm_rdata   = rdata_q;
   assign bus.sm_rresp   = rresp_q;
   assign disp_hex_r     = disp_q;
endmodule

// File: tb/tb_axi_lite_regfile_disp.sv
// Testbench for axi_lite_regfile_disp: directed scenarios plus a randomized
// mix of reads and writes, checked against an array model of the registers.
module tb_axi_lite_regfile_disp;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 12;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] disp_hex_r;

   always #5 clk = ~clk;

   axi_lite_regfile_disp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   axi_lite_regfile_disp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .disp_hex_r (disp_hex_r)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0] seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
   logic [7:0] model_mem [16];
   logic [7:0] model_disp;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      model_disp = 8'h3F;
   endtask

   task automatic model_write(input logic [3:0] a, input logic [7:0] d, output logic [1:0] er);
      if (int'(a) < DEPTH) begin
         model_mem[a] = d;
         er = 2'b00;
      end else begin
         er = 2'b10;
      end
   endtask

   task automatic model_read(input logic [3:0] a, output logic [7:0] ed, output logic [1:0] er);
      if (int'(a) < DEPTH) begin
         ed = model_mem[a];
         er = 2'b00;
         model_disp = seg_tbl[ed[3:0]];
      end else begin
         ed = 8'h00;
         er = 2'b10;
      end
   endtask

   // Full write with bready held high. lat = edges from the last of AW/W to
   // bvalid (-1 on timeout); ardy/wrdy are the readies seen while bvalid is up.
   task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                           output logic [1:0] resp, output int lat,
                           output logic ardy, output logic wrdy);
      bit aw_done = 0, w_done = 0, faw, fw;
      int hs = -1;
      lat = -1; resp = 2'bxx; ardy = 1'bx; wrdy = 1'bx;
      bus.ms_awaddr = a; bus.ms_wdata = d;
      bus.ms_awvalid = 1'b1; bus.ms_wvalid = 1'b1; bus.ms_bready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         faw = bus.ms_awvalid && bus.sm_awready;
         fw  = bus.ms_wvalid && bus.sm_wready;
         @(posedge clk); #1;
         if (faw) begin bus.ms_awvalid = 1'b0; aw_done = 1; end
         if (fw)  begin bus.ms_wvalid = 1'b0;  w_done = 1; end
         if (hs < 0 && aw_done && w_done) hs = i - 1;
         if (bus.sm_bvalid) begin
            if (hs >= 0) lat = i - hs;
            resp = bus.sm_bresp; ardy = bus.sm_awready; wrdy = bus.sm_wready;
            break;
         end
      end
      @(posedge clk); #1;
      bus.ms_awvalid = 1'b0; bus.ms_wvalid = 1'b0; bus.ms_bready = 1'b0;
   endtask

   // Full read with rready held high; lat = edges from AR handshake to rvalid.
   task automatic do_read(input logic [3:0] a, output logic [7:0] d,
                          output logic [1:0] resp, output int lat);
      bit far;
      int hs = -1;
      lat = -1; d = 8'hxx; resp = 2'bxx;
      bus.ms_araddr = a; bus.ms_arvalid = 1'b1; bus.ms_rready = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         far = bus.ms_arvalid && bus.sm_arready;
         @(posedge clk); #1;
         if (far) begin bus.ms_arvalid = 1'b0; hs = i - 1; end
         if (bus.sm_rvalid) begin
            if (hs >= 0) lat = i - hs;
            d = bus.sm_rdata; resp = bus.sm_rresp;
            break;
         end
      end
      @(posedge clk); #1;
      bus.ms_arvalid = 1'b0; bus.ms_rready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      checks++; if ({bus.sm_awready, bus.sm_wready, bus.sm_arready} !== 3'b111) begin
         failures++; $display("FAIL reset_readies got=%b exp=111", {bus.sm_awready, bus.sm_wready, bus.sm_arready}); end
      checks++; if ({bus.sm_bvalid, bus.sm_rvalid} !== 2'b00) begin
         failures++; $display("FAIL reset_valids got=%b exp=00", {bus.sm_bvalid, bus.sm_rvalid}); end
      checks++; if ({bus.sm_bresp, bus.sm_rresp, bus.sm_rdata} !== 12'h000) begin
         failures++; $display("FAIL reset_resp_data got=%h exp=000", {bus.sm_bresp, bus.sm_rresp, bus.sm_rdata}); end
      checks++; if (disp_hex_r !== 8'h3F) begin
         failures++; $display("FAIL reset_disp got=%h exp=3f", disp_hex_r); end
   endtask

   task automatic test_read_after_reset();
      logic [7:0] d, ed; logic [1:0] r, er; int lat;
      checks++; if (bus.sm_arready !== 1'b1) begin
         failures++; $display("FAIL rd0_arready got=%b exp=1", bus.sm_arready); end
      model_read(4'd3, ed, er);
      do_read(4'd3, d, r, lat);
      checks++; if (lat !== 1) begin failures++; $display("FAIL rd0_latency got=%0d exp=1", lat); end
      checks++; if ({d, r} !== {ed, er}) begin failures++; $display("FAIL rd0_data got=%h/%b exp=%h/%b", d, r, ed, er); end
      checks++; if (disp_hex_r !== model_disp) begin failures++; $display("FAIL rd0_disp got=%h exp=%h", disp_hex_r, model_disp); end
   endtask

   task automatic test_write_same_cycle();
      logic [7:0] d, ed; logic [1:0] r, er, br, ebr; int lat; logic ar, wr;
      model_write(4'd3, 8'hA4, ebr);
      do_write(4'd3, 8'hA4, br, lat, ar, wr);
      checks++; if (lat !== 1) begin failures++; $display("FAIL wr_same_latency got=%0d exp=1", lat); end
      checks++; if (br !== ebr) begin failures++; $display("FAIL wr_same_bresp got=%b exp=%b", br, ebr); end
      checks++; if ({ar, wr} !== 2'b00) begin failures++; $display("FAIL wr_same_readies got=%b exp=00", {ar, wr}); end
      model_read(4'd3, ed, er);
      do_read(4'd3, d, r, lat);
      checks++; if ({d, r} !== {ed, er}) begin failures++; $display("FAIL wr_same_readback got=%h/%b exp=%h/%b", d, r, ed, er); end
      checks++; if (disp_hex_r !== model_disp) begin failures++; $display("FAIL wr_same_disp got=%h exp=%h", disp_hex_r, model_disp); end
   endtask

   task automatic test_w_before_aw();
      logic [7:0] d, ed; logic [1:0] r, er, ebr; int lat;
      model_write(4'd7, 8'h5B, ebr);
      bus.ms_wdata = 8'h5B; bus.ms_wvalid = 1'b1; bus.ms_bready = 1'b0;
      @(posedge clk); #1;
      bus.ms_wvalid = 1'b0;
      checks++; if ({bus.sm_wready, bus.sm_awready} !== 2'b01) begin
         failures++; $display("FAIL wfirst_readies got=%b exp=01", {bus.sm_wready, bus.sm_awready}); end
      @(posedge clk); #1;
      bus.ms_awaddr = 4'd7; bus.ms_awvalid = 1'b1;
      @(posedge clk); #1;
      bus.ms_awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if ({bus.sm_bvalid, bus.sm_bresp} !== {1'b1, ebr}) begin
            failures++; $display("FAIL wfirst_bhold%0d got=%b exp=%b", i, {bus.sm_bvalid, bus.sm_bresp}, {1'b1, ebr}); end
         @(posedge clk); #1;
      end
      bus.ms_bready = 1'b1;
      checks++; if (bus.sm_bvalid !== 1'b1) begin failures++; $display("FAIL wfirst_bvalid_before_ready got=%b exp=1", bus.sm_bvalid); end
      @(posedge clk); #1;
      bus.ms_bready = 1'b0;
      checks++; if ({bus.sm_bvalid, bus.sm_awready, bus.sm_wready} !== 3'b011) begin
         failures++; $display("FAIL wfirst_after_b got=%b exp=011", {bus.sm_bvalid, bus.sm_awready, bus.sm_wready}); end
      model_read(4'd7, ed, er);
      do_read(4'd7, d, r, lat);
      checks++; if ({d, r} !== {ed, er}) begin failures++; $display("FAIL wfirst_readback got=%h/%b exp=%h/%b", d, r, ed, er); end
   endtask

   task automatic test_unmapped();
      logic [7:0] d, ed; logic [1:0] r, er, br, ebr; int lat; logic ar, wr;
      model_write(4'd13, 8'hFF, ebr);
      do_write(4'd13, 8'hFF, br, lat, ar, wr);
      checks++; if (br !== ebr) begin failures++; $display("FAIL unmapped_bresp got=%b exp=%b", br, ebr); end
      model_read(4'd13, ed, er);
      do_read(4'd13, d, r, lat);
      checks++; if ({d, r} !== {ed, er}) begin failures++; $display("FAIL unmapped_read got=%h/%b exp=%h/%b", d, r, ed, er); end
      checks++; if (disp_hex_r !== model_disp) begin failures++; $display("FAIL unmapped_disp got=%h exp=%h", disp_hex_r, model_disp); end
      for (int a = 0; a < DEPTH; a++) begin
         model_read(4'(a), ed, er);
         do_read(4'(a), d, r, lat);
         checks++; if ({d, r} !== {ed, er}) begin failures++; $display("FAIL unmapped_array%0d got=%h/%b exp=%h/%b", a, d, r, ed, er); end
      end
   endtask

   task automatic test_rw_collision();
      logic [7:0] d, ed; logic [1:0] r, er, br, ebr; int lat; logic ar, wr;
      model_write(4'd2, 8'h11, ebr);
      do_write(4'd2, 8'h11, br, lat, ar, wr);
      model_read(4'd2, ed, er);
      model_write(4'd2, 8'h22, ebr);
      bus.ms_awaddr = 4'd2; bus.ms_wdata = 8'h22; bus.ms_araddr = 4'd2;
      bus.ms_awvalid = 1'b1; bus.ms_wvalid = 1'b1; bus.ms_arvalid = 1'b1;
      bus.ms_bready = 1'b1; bus.ms_rready = 1'b1;
      @(posedge clk); #1;
      bus.ms_awvalid = 1'b0; bus.ms_wvalid = 1'b0; bus.ms_arvalid = 1'b0;
      checks++; if ({bus.sm_bvalid, bus.sm_rvalid} !== 2'b11) begin
         failures++; $display("FAIL collide_valids got=%b exp=11", {bus.sm_bvalid, bus.sm_rvalid}); end
      checks++; if (bus.sm_rdata !== ed) begin failures++; $display("FAIL collide_old_data got=%h exp=%h", bus.sm_rdata, ed); end
      @(posedge clk); #1;
      bus.ms_bready = 1'b0; bus.ms_rready = 1'b0;
      model_read(4'd2, ed, er);
      do_read(4'd2, d, r, lat);
      checks++; if ({d, r} !== {ed, er}) begin failures++; $display("FAIL collide_new_data got=%h/%b exp=%h/%b", d, r, ed, er); end
      checks++; if (disp_hex_r !== model_disp) begin failures++; $display("FAIL collide_disp got=%h exp=%h", disp_hex_r, model_disp); end
   endtask

   task automatic test_random();
      logic [7:0] d, ed, wd; logic [1:0] r, er, br, ebr; int lat; logic ar, wr; logic [3:0] a;
      for (int n = 0; n < 60; n++) begin
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            wd = 8'($urandom);
            model_write(a, wd, ebr);
            do_write(a, wd, br, lat, ar, wr);
            checks++; if ({lat == 1, br} !== {1'b1, ebr}) begin
               failures++; $display("FAIL rand_write%0d a=%0d got=lat%0d/%b exp=lat1/%b", n, a, lat, br, ebr); end
         end else begin
            model_read(a, ed, er);
            do_read(a, d, r, lat);
            checks++; if ({lat == 1, d, r, disp_hex_r} !== {1'b1, ed, er, model_disp}) begin
               failures++; $display("FAIL rand_read%0d a=%0d got=lat%0d/%h/%b/%h exp=lat1/%h/%b/%h",
                                    n, a, lat, d, r, disp_hex_r, ed, er, model_disp); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d; logic [1:0] r; int lat;
      bus.ms_awaddr = 4'd5; bus.ms_wdata = 8'h99; bus.ms_araddr = 4'd3;
      bus.ms_awvalid = 1'b1; bus.ms_wvalid = 1'b1; bus.ms_arvalid = 1'b1;
      bus.ms_bready = 1'b0; bus.ms_rready = 1'b0;
      @(posedge clk); #1;
      bus.ms_awvalid = 1'b0; bus.ms_wvalid = 1'b0; bus.ms_arvalid = 1'b0;
      checks++; if ({bus.sm_bvalid, bus.sm_rvalid} !== 2'b11) begin
         failures++; $display("FAIL rstmid_pre_valids got=%b exp=11", {bus.sm_bvalid, bus.sm_rvalid}); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      checks++; if ({bus.sm_bvalid, bus.sm_rvalid} !== 2'b00) begin
         failures++; $display("FAIL rstmid_valids got=%b exp=00", {bus.sm_bvalid, bus.sm_rvalid}); end
      checks++; if ({bus.sm_awready, bus.sm_wready, bus.sm_arready} !== 3'b111) begin
         failures++; $display("FAIL rstmid_readies got=%b exp=111", {bus.sm_awready, bus.sm_wready, bus.sm_arready}); end
      checks++; if (disp_hex_r !== 8'h3F) begin failures++; $display("FAIL rstmid_disp got=%h exp=3f", disp_hex_r); end
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), d, r, lat);
         checks++; if ({d, r} !== {8'h00, (a < DEPTH) ? 2'b00 : 2'b10}) begin
            failures++; $display("FAIL rstmid_read%0d got=%h/%b exp=00/%b", a, d, r, (a < DEPTH) ? 2'b00 : 2'b10); end
      end
   endtask

   initial begin
      bus.ms_awvalid = 1'b0; bus.ms_awaddr = '0; bus.ms_wvalid = 1'b0; bus.ms_wdata = '0;
      bus.ms_bready = 1'b0; bus.ms_arvalid = 1'b0; bus.ms_araddr = '0; bus.ms_rready = 1'b0;
      test_reset();
      test_read_after_reset();
      test_write_same_cycle();
      test_w_before_aw();
      test_unmapped();
      test_rw_collision();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_lite_regfile_disp.md
Name: axi_lite_regfile_disp

Overview:
- Parametrised successor of the team's 4-bit AXI-style register slave.
- AXI-Lite-style slave with independent AW, W, B, AR and R channels.
- Holds a DEPTH x DATA_W register array, returns OKAY/SLVERR responses, and drives a seven-segment display with the last read data.
- Sits between the switch/button master logic (ms_* signals) and the board display.

Parameters:
- ADDR_W, 4, address width in bits.
- DATA_W, 8, data width in bits; must be >= 4.
- DEPTH, 12, number of implemented registers; must be <= 2^ADDR_W. Addresses >= DEPTH are unmapped.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ms_awvalid  in  1  write address valid.
- ms_awaddr  in  ADDR_W  write address.
- sm_awready  out  1  write address ready.
- ms_wvalid  in  1  write data valid.
- ms_wdata  in  DATA_W  write data.
- sm_wready  out  1  write data ready.
- sm_bvalid  out  1  write response valid.
- sm_bresp  out  2  write response: 00 = OKAY, 10 = SLVERR.
- ms_bready  in  1  write response ready.
- ms_arvalid  in  1  read address valid.
- ms_araddr  in  ADDR_W  read address.
- sm_arready  out  1  read address ready.
- sm_rvalid  out  1  read data valid.
- sm_rdata  out  DATA_W  read data.
- sm_rresp  out  2  read response: 00 = OKAY, 10 = SLVERR.
- ms_rready  in  1  read data ready.
- disp_hex_r  out  8  seven-segment pattern {dp,g,f,e,d,c,b,a}, active-high.

Behaviour:
- Reset (synchronous, active-high):
  - All array entries = 0.
  - sm_awready = sm_wready = sm_arready = 1.
  - sm_bvalid = sm_rvalid = 0.
  - sm_bresp = sm_rresp = 00; sm_rdata = 0.
  - disp_hex_r = 8'h3F (digit 0).
  - Capture flags cleared. Reset mid-transaction aborts it; no partial write.
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: sm_awready = !aw_captured; sm_wready = !w_captured.
  - AW and W handshakes may occur in either order or in the same cycle.
  - Address and data are latched independently.
  - On the clock edge where the second of the two completes (bypassing the register if that one arrives on the same edge):
    - If addr < DEPTH: write array[addr], bresp = 00.
    - Otherwise: no write, bresp = 10.
    - Go to W_RESP; sm_bvalid = 1 from the next cycle.
  - W_RESP: sm_awready = sm_wready = 0. sm_bvalid and sm_bresp are held stable until ms_bready = 1. On that edge go to W_COLLECT and clear the flags.
  - Minimum write latency: AW+W edge to bvalid = 1 cycle.
- Read FSM, states R_ADDR and R_DATA:
  - R_ADDR: sm_arready = 1. On an ms_arvalid edge:
    - If addr < DEPTH: sm_rdata = array[addr], rresp = 00.
    - Otherwise: sm_rdata = 0, rresp = 10.
    - Go to R_DATA.
  - R_DATA: sm_arready = 0; sm_rvalid = 1. sm_rdata and sm_rresp are held until ms_rready = 1, then return to R_ADDR. This gives a one-cycle arready bubble between reads.
  - Read latency: AR edge to rvalid = 1 cycle.
- Read/write channels are fully independent and may be active concurrently.
- Read and write to the same address committing on the same edge: the read returns the old (pre-write) value.
- Display:
  - On the R handshake edge with rresp = 00, disp_hex_r is set to the encoding of sm_rdata[3:0].
  - SLVERR reads leave the display unchanged.
  - Encodings: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71; dp = 0.
- The slave never drops a valid before the matching ready. Master misbehaviour is not checked.

Test Plan:
1. Reset, then AR addr 3 with rready held 1:
   - arready = 1 before the handshake.
   - rvalid = 1 one cycle after the handshake, rdata = 0x00, rresp = 00.
   - disp_hex_r = 3F.
2. AW addr 3 and W 0xA4 in the same cycle, bready = 1:
   - bvalid = 1 next cycle with bresp = 00; awready and wready = 0 while bvalid.
   - Then AR addr 3 -> rdata = 0xA4 and disp_hex_r = 66.
3. W 0x5B issued 2 cycles before AW addr 7, bready held 0 for 3 cycles:
   - wready drops after the W handshake; bvalid is held for 3 cycles.
   - Readback of addr 7 = 0x5B.
4. AW addr 13 (>= DEPTH) with W 0xFF:
   - bresp = 10 and the array is unchanged.
   - AR addr 13 -> rdata = 0, rresp = 10, disp_hex_r unchanged.
5. Addr 2 holds 0x11. AW/W of 0x22 to addr 2 committing on the same edge as AR addr 2:
   - rdata = 0x11.
   - A following read returns 0x22.
6. Assert reset while bvalid = 1 and rvalid = 1:
   - Next cycle all valids = 0, readies = 1, disp_hex_r = 3F.
   - Every address reads 0.
